// File: rtl/alu_exec_stage_if.sv
// Handshake and operand/result bus for alu_exec_stage.
// master: upstream issuer/consumer; slave: the execute stage.
interface alu_exec_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec_stage.sv
// ALU execute stage with valid/ready handshake and registered result/zero.
// Shifts are iterative (one bit per cycle) by default; defining
// ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter instead.
module alu_exec_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  alu_exec_stage_if.slave   bus
);
  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_n;
  logic [3:0]      op, op_n;
  logic [XLEN-1:0] work, work_n;
  logic [SHW-1:0]  cnt, cnt_n;
  logic [XLEN-1:0] result_q, result_n;
  logic            zero_q, zero_n;

  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] step;

  assign shamt    = bus.src_b[SHW-1:0];
  assign is_shift = (bus.alu_control == OP_SLL) || (bus.alu_control == OP_SRL) ||
                    (bus.alu_control == OP_SRA);

  // Single-cycle ops; unlisted codes fall back to ADD.
  always_comb begin
    alu_out = bus.src_a + bus.src_b;
    case (bus.alu_control)
      OP_SUB:  alu_out = bus.src_a - bus.src_b;
      OP_AND:  alu_out = bus.src_a & bus.src_b;
      OP_OR:   alu_out = bus.src_a | bus.src_b;
      OP_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      default: alu_out = bus.src_a + bus.src_b;
    endcase
  end

  // One-bit step of the iterative shifter on the working register.
  always_comb begin
    step = {1'b0, work[XLEN-1:1]};
    case (op)
      OP_SLL:  step = {work[XLEN-2:0], 1'b0};
      OP_SRA:  step = {work[XLEN-1], work[XLEN-1:1]};
      default: step = {1'b0, work[XLEN-1:1]};
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0] barrel;

  // Full barrel shift straight from the operands.
  always_comb begin
    barrel = bus.src_a >> shamt;
    case (bus.alu_control)
      OP_SLL:  barrel = bus.src_a << shamt;
      OP_SRA:  barrel = $unsigned($signed(bus.src_a) >>> shamt);
      default: barrel = bus.src_a >> shamt;
    endcase
  end
`endif

  // Next-state and next-datapath values; state is held unless a transition applies.
  always_comb begin
    state_n  = state;
    op_n     = op;
    work_n   = work;
    cnt_n    = cnt;
    result_n = result_q;
    zero_n   = zero_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          op_n = bus.alu_control;
          if (!is_shift) begin
            result_n = alu_out;
            zero_n   = (alu_out == '0);
            state_n  = DONE;
          end
`ifdef ALU_FAST_SHIFT_EN
          else begin
            result_n = barrel;
            zero_n   = (barrel == '0);
            state_n  = DONE;
          end
`else
          else if (shamt == '0) begin
            result_n = bus.src_a;
            zero_n   = (bus.src_a == '0);
            state_n  = DONE;
          end else begin
            work_n  = bus.src_a;
            cnt_n   = shamt;
            state_n = SHIFT;
          end
`endif
        end
      end
      SHIFT: begin
        work_n = step;
        cnt_n  = cnt - 1'b1;
        if (cnt == SHW'(1)) begin
          result_n = step;
          zero_n   = (step == '0);
          state_n  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op       <= '0;
      work     <= '0;
      cnt      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state    <= state_n;
      op       <= op_n;
      work     <= work_n;
      cnt      <= cnt_n;
      result_q <= result_n;
      zero_q   <= zero_n;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with hand-computed expectations.
// Build with or without ALU_FAST_SHIFT_EN; shift latencies adapt.
module tb_alu_exec_stage;
  logic clk;
  logic rst;
  int unsigned vectors;
  int unsigned miscompares;

  alu_exec_stage_if #(.XLEN(32)) bus ();

  alu_exec_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned shlat(input int unsigned n);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    return 1 + n;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure accept-to-out_valid latency, check, then consume it.
  task automatic do_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic exp_z,
                       input int unsigned exp_lat, input logic ordy);
    int unsigned lat;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.alu_control = ctrl;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.out_ready   = ordy;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".res"}, bus.result, exp_res);
    check({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, exp_z});
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, ".idle"}, {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
  endtask

  initial begin
    logic seen;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.alu_control = 4'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.hs", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
    check("rst.res", bus.result, 32'h0);
    check("rst.zero", {31'b0, bus.zero}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    do_op("add",     4'b0000, 32'h5, 32'h3, 32'h8, 1'b0, 1, 1'b0);
    do_op("sub_eq",  4'b0001, 32'h7, 32'h7, 32'h0, 1'b1, 1, 1'b0);
    do_op("sub_neg", 4'b0001, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);
    do_op("add_wrap",4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1, 1'b0);
    do_op("and",     4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1, 1'b0);
    do_op("or",      4'b0011, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 1'b0, 1, 1'b0);
    do_op("slt_t",   4'b0101, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1, 1'b0);
    do_op("slt_f",   4'b0101, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b0);
    do_op("illegal", 4'b1111, 32'h2, 32'h3, 32'h5, 1'b0, 1, 1'b0);
    do_op("sra4",    4'b1010, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, shlat(4), 1'b0);
    do_op("srl4",    4'b1001, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, shlat(4), 1'b0);
    do_op("sll0",    4'b0110, 32'h1, 32'h0, 32'h1, 1'b0, 1, 1'b0);
    do_op("sll31",   4'b0110, 32'h1, 32'd31, 32'h8000_0000, 1'b0, shlat(31), 1'b0);
    do_op("sll_amt", 4'b0110, 32'h1, 32'h21, 32'h2, 1'b0, shlat(1), 1'b0);
    do_op("srl_out", 4'b1001, 32'h80, 32'h3, 32'h10, 1'b0, shlat(3), 1'b1);
    do_op("srl_z",   4'b1001, 32'h1, 32'h1, 32'h0, 1'b1, shlat(1), 1'b0);

    // Hold DONE with out_ready low while a new op is offered.
    do_op("hold_pre", 4'b0000, 32'd10, 32'd20, 32'd30, 1'b0, 1, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_control = 4'b0000;
    bus.src_a = 32'd10; bus.src_b = 32'd20;
    @(posedge clk); #1;
    @(negedge clk);
    bus.alu_control = 4'b0001; bus.src_a = 32'd1; bus.src_b = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold.res", bus.result, 32'd30);
      check("hold.hs", {30'b0, bus.in_ready, bus.out_valid}, 32'h1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("hold.rel", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
    repeat (3) @(posedge clk);
    #1;
    check("hold.noop", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);

    // Reset during an SLL by 20, five cycles in.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_control = 4'b0110;
    bus.src_a = 32'h1; bus.src_b = 32'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid.hs", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);
    check("rst_mid.res", bus.result, 32'h0);
    check("rst_mid.zero", {31'b0, bus.zero}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
`ifndef ALU_FAST_SHIFT_EN
    check("rst_mid.never_valid", {31'b0, seen}, 32'h0);
`endif
    check("rst_mid.after", {30'b0, bus.in_ready, bus.out_valid}, 32'h2);

    do_op("post_rst", 4'b0000, 32'h1, 32'h1, 32'h2, 1'b0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width; shift amount is src_b[log2(XLEN)-1:0].
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operation offered.
REQ-005 SHALL have port: in_ready  output  1  stage can accept an operation.
REQ-006 SHALL have port: alu_control  input  4  operation code from the ALU decoder.
REQ-007 SHALL have port: src_a  input  XLEN  operand A.
REQ-008 SHALL have port: src_b  input  XLEN  operand B or shift amount.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: result  output  XLEN  registered ALU result.
REQ-012 SHALL have port: zero  output  1  registered flag, 1 when result is all-zero.

Function
REQ-013 SHALL decode alu_control: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLT (signed, result 1/0), 0110 SLL, 1001 SRL, 1010 SRA; any other code SHALL execute ADD.
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept an operation on a rising edge where in_valid&&in_ready, capturing alu_control, src_a, src_b.
REQ-016 Non-shift op: SHALL register result and zero at the accept edge and enter DONE (out_valid high the next cycle, latency 1).
REQ-017 Shift op: SHALL load src_a into the working register and shamt into a down-counter at the accept edge; shamt=0 SHALL go directly to DONE with result=src_a.
REQ-018 In SHIFT, each edge SHALL shift the working register one bit (SLL zero-fill, SRL zero-fill, SRA sign-fill) and decrement the counter; on the edge the counter goes 1->0 it SHALL enter DONE; latency 1+shamt cycles.
REQ-019 In DONE, result and zero SHALL remain stable until out_ready=1; on that edge the FSM SHALL return to IDLE; no new op is accepted in the same edge.
REQ-020 ADD/SUB SHALL wrap modulo 2^XLEN; no overflow or carry output.
REQ-021 Inputs SHALL be ignored while in_ready=0; out_ready SHALL be ignored outside DONE.

Reset
REQ-022 rst=1 at a rising edge SHALL force IDLE, result=0, zero=0, counter=0, out_valid=0, in_ready=1 the following cycle.
REQ-023 rst SHALL take priority over every handshake, including mid-SHIFT and DONE; the in-flight op SHALL be discarded without producing out_valid.

Configuration
REQ-024 Macro ALU_FAST_SHIFT_EN SHALL select the shifter implementation.
REQ-025 With ALU_FAST_SHIFT_EN defined, shifts SHALL use a single-cycle barrel shifter, SHIFT is never entered, and all ops have latency 1.
REQ-026 Without ALU_FAST_SHIFT_EN, shifts SHALL be iterative per REQ-017/018; results SHALL be identical in both builds.

Verification
REQ-027 After rst, ADD 0x00000005+0x00000003 -> out_valid 1 cycle after accept, result=0x00000008, zero=0.
REQ-028 SUB 0x00000007-0x00000007 -> result=0x00000000, zero=1; SUB 0x00000000-0x00000001 -> 0xFFFFFFFF.
REQ-029 SLT 0xFFFFFFFF vs 0x00000001 -> result=1; SRA 0x80000000 by 4 -> 0xF8000000 after 5 cycles (iterative) or 1 cycle (ALU_FAST_SHIFT_EN); SRL same -> 0x08000000.
REQ-030 SLL 0x00000001 by 0 -> result=0x00000001 with latency 1; SLL by 31 -> 0x80000000 with latency 32 (iterative).
REQ-031 Hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, new in_valid ignored; raise out_ready -> IDLE next cycle.
REQ-032 Assert rst during SHIFT (SLL by 20, cycle 5) -> next cycle IDLE, out_valid never asserted, result=0.
